// File: rtl/usb_cmd_pkg.sv
// Shared constants and state encodings for the USB command controller.
package usb_cmd_pkg;

    localparam logic [7:0] CMD_HDR = 8'hA5;
    localparam logic [7:0] RSP_HDR = 8'h5A;
    localparam logic [7:0] OP_WR   = 8'h01;
    localparam logic [7:0] OP_RD   = 8'h02;

    typedef enum logic [2:0] {
        HUNT,
        OPC,
        ADDR,
        DHI,
        DLO,
        EXEC,
        RD_CAP
    } parse_state_e;

    typedef enum logic [1:0] {
        IDLE,
        RESP,
        STREAM
    } arb_state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/usb_tx_arb.sv
// Transmit FIFO arbiter: 4-byte read-response buffer versus bulk scan-data stream.
module usb_tx_arb
    import usb_cmd_pkg::*;
#(
    parameter int unsigned BURST_LEN  = 64,
    parameter int unsigned TX_HIGH_WM = 496
) (
    input  logic        clk_i,
    input  logic        nrst,
    input  logic        rsp_load_i,
    input  logic [7:0]  rsp_addr_i,
    input  logic [15:0] rsp_rdata_i,
    output logic        rsp_full_o,
    output logic        txe_wrreq_o,
    output logic [7:0]  txe_wrdata_o,
    input  logic [8:0]  txe_wrusedw_i,
    input  logic        txe_wrfull_i,
    input  logic [7:0]  stream_data_i,
    input  logic        stream_valid_i,
    output logic        stream_ready_o
);

    localparam int unsigned    BcW       = $clog2(BURST_LEN + 1);
    localparam logic [BcW-1:0] BurstLast = BcW'(BURST_LEN - 1);
    localparam logic [9:0]     HighWm    = 10'(TX_HIGH_WM);

    arb_state_e     state_q;
    logic           full_q;
    logic [7:0]     addr_q;
    logic [15:0]    rdata_q;
    logic [1:0]     idx_q;
    logic [BcW-1:0] burst_q;
    logic           wrreq_q;
    logic [7:0]     wrdata_q;

    logic           tx_ok;
    logic           accept;
    logic [7:0]     rsp_byte;

    assign tx_ok          = !txe_wrfull_i && ({1'b0, txe_wrusedw_i} < HighWm);
    assign stream_ready_o = (state_q == STREAM) && tx_ok;
    assign accept         = stream_ready_o && stream_valid_i;

    assign rsp_full_o   = full_q;
    assign txe_wrreq_o  = wrreq_q;
    assign txe_wrdata_o = wrdata_q;

    always_comb begin
        rsp_byte = RSP_HDR;
        unique case (idx_q)
            2'd0: rsp_byte = RSP_HDR;
            2'd1: rsp_byte = addr_q;
            2'd2: rsp_byte = rdata_q[15:8];
            2'd3: rsp_byte = rdata_q[7:0];
            default: rsp_byte = RSP_HDR;
        endcase
    end

    always_ff @(posedge clk_i or negedge nrst) begin
        if (!nrst) begin
            state_q  <= IDLE;
            full_q   <= 1'b0;
            addr_q   <= '0;
            rdata_q  <= '0;
            idx_q    <= '0;
            burst_q  <= '0;
            wrreq_q  <= 1'b0;
            wrdata_q <= '0;
        end else begin
            wrreq_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    // A pending response always beats the stream.
                    if (full_q) begin
                        state_q <= RESP;
                        idx_q   <= '0;
                    end else if (stream_valid_i) begin
                        state_q <= STREAM;
                        burst_q <= '0;
                    end
                end
                RESP: begin
                    if (tx_ok) begin
                        wrreq_q  <= 1'b1;
                        wrdata_q <= rsp_byte;
                        idx_q    <= idx_q + 2'd1;
                        if (idx_q == 2'd3) begin
                            full_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end
                STREAM: begin
                    if (accept) begin
                        wrreq_q  <= 1'b1;
                        wrdata_q <= stream_data_i;
                        burst_q  <= burst_q + 1'b1;
                        if (burst_q == BurstLast) begin
                            state_q <= IDLE;
                        end
                    end else if (!stream_valid_i && full_q) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
            // The parser only loads when the buffer is empty, so this never races the clear.
            if (rsp_load_i) begin
                full_q  <= 1'b1;
                addr_q  <= rsp_addr_i;
                rdata_q <= rsp_rdata_i;
            end
        end
    end

endmodule

// File: rtl/usb_cmd_ctrl.sv
// Command controller: fetches host bytes, decodes 5-byte packets, executes register
// accesses and hands read responses to the transmit arbiter.
module usb_cmd_ctrl
    import usb_cmd_pkg::*;
#(
    parameter int unsigned BURST_LEN  = 64,
    parameter int unsigned TX_HIGH_WM = 496,
    parameter int unsigned TIMEOUT    = 65535
) (
    input  logic        clk_i,
    input  logic        nrst,
    output logic        rxf_rdreq_o,
    input  logic [7:0]  rxf_rddata_i,
    input  logic [8:0]  rxf_rdusedw_i,
    output logic        txe_wrreq_o,
    output logic [7:0]  txe_wrdata_o,
    input  logic [8:0]  txe_wrusedw_i,
    input  logic        txe_wrfull_i,
    output logic        reg_wr_o,
    output logic        reg_rd_o,
    output logic [7:0]  reg_addr_o,
    output logic [15:0] reg_wdata_o,
    input  logic [15:0] reg_rdata_i,
    input  logic [7:0]  stream_data_i,
    input  logic        stream_valid_i,
    output logic        stream_ready_o,
    output logic [7:0]  err_cnt_o
);

    localparam int unsigned    ToW   = $clog2(TIMEOUT + 1);
    localparam logic [ToW-1:0] ToMax = ToW'(TIMEOUT);

    parse_state_e   state_q;
    logic           rdreq_q;
    logic           byte_vld_q;
    logic [ToW-1:0] to_cnt_q;
    logic [7:0]     op_q;
    logic [7:0]     addr_q;
    logic [7:0]     dhi_q;
    logic [7:0]     dlo_q;
    logic           reg_wr_q;
    logic           reg_rd_q;
    logic [7:0]     reg_addr_q;
    logic [15:0]    reg_wdata_q;
    logic [7:0]     err_q;

    logic           in_frame;
    logic           fetch_ok;
    logic           op_valid;
    logic           err_hit;
    logic           rsp_full;
    logic           rsp_load;

    assign in_frame = state_q inside {OPC, ADDR, DHI, DLO};
    assign op_valid = (rxf_rddata_i == OP_WR) || (rxf_rddata_i == OP_RD);

    // A DLO byte landing now moves us to EXEC, so a fetch issued now would land there and be lost.
    assign fetch_ok = !rdreq_q && (rxf_rdusedw_i != '0) && (in_frame || state_q == HUNT) &&
                      !(state_q == DLO && byte_vld_q);

    assign err_hit = (byte_vld_q && state_q == HUNT && rxf_rddata_i != CMD_HDR) ||
                     (byte_vld_q && state_q == OPC && !op_valid) ||
                     (in_frame && !byte_vld_q && to_cnt_q == ToMax);

    // reg_rd_q is still high on the first RD_CAP cycle; read data arrives one cycle later.
    assign rsp_load = (state_q == RD_CAP) && !reg_rd_q;

    assign rxf_rdreq_o = rdreq_q;
    assign reg_wr_o    = reg_wr_q;
    assign reg_rd_o    = reg_rd_q;
    assign reg_addr_o  = reg_addr_q;
    assign reg_wdata_o = reg_wdata_q;
    assign err_cnt_o   = err_q;

    always_ff @(posedge clk_i or negedge nrst) begin
        if (!nrst) begin
            state_q     <= HUNT;
            rdreq_q     <= 1'b0;
            byte_vld_q  <= 1'b0;
            to_cnt_q    <= '0;
            op_q        <= '0;
            addr_q      <= '0;
            dhi_q       <= '0;
            dlo_q       <= '0;
            reg_wr_q    <= 1'b0;
            reg_rd_q    <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
        end else begin
            rdreq_q    <= fetch_ok;
            byte_vld_q <= rdreq_q;
            reg_wr_q   <= 1'b0;
            reg_rd_q   <= 1'b0;
            unique case (state_q)
                HUNT: begin
                    if (byte_vld_q && rxf_rddata_i == CMD_HDR) state_q <= OPC;
                end
                OPC: begin
                    if (byte_vld_q) begin
                        op_q    <= rxf_rddata_i;
                        state_q <= op_valid ? ADDR : HUNT;
                    end
                end
                ADDR: begin
                    if (byte_vld_q) begin
                        addr_q  <= rxf_rddata_i;
                        state_q <= DHI;
                    end
                end
                DHI: begin
                    if (byte_vld_q) begin
                        dhi_q   <= rxf_rddata_i;
                        state_q <= DLO;
                    end
                end
                DLO: begin
                    if (byte_vld_q) begin
                        dlo_q   <= rxf_rddata_i;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    if (op_q == OP_WR) begin
                        reg_wr_q    <= 1'b1;
                        reg_addr_q  <= addr_q;
                        reg_wdata_q <= {dhi_q, dlo_q};
                        state_q     <= HUNT;
                    end else if (!rsp_full) begin
                        reg_rd_q   <= 1'b1;
                        reg_addr_q <= addr_q;
                        state_q    <= RD_CAP;
                    end
                end
                RD_CAP: begin
                    if (!reg_rd_q) state_q <= HUNT;
                end
                default: state_q <= HUNT;
            endcase
            // Timeout overrides the per-state transition when it fires.
            if (in_frame) begin
                if (byte_vld_q) begin
                    to_cnt_q <= '0;
                end else if (to_cnt_q == ToMax) begin
                    to_cnt_q <= '0;
                    state_q  <= HUNT;
                end else begin
                    to_cnt_q <= to_cnt_q + 1'b1;
                end
            end else begin
                to_cnt_q <= '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge nrst) begin
        if (!nrst) begin
            err_q <= '0;
        end else if (err_hit) begin
            err_q <= sat_inc8(err_q);
        end
    end

    usb_tx_arb #(
        .BURST_LEN  (BURST_LEN),
        .TX_HIGH_WM (TX_HIGH_WM)
    ) u_tx_arb (
        .clk_i          (clk_i),
        .nrst           (nrst),
        .rsp_load_i     (rsp_load),
        .rsp_addr_i     (reg_addr_q),
        .rsp_rdata_i    (reg_rdata_i),
        .rsp_full_o     (rsp_full),
        .txe_wrreq_o    (txe_wrreq_o),
        .txe_wrdata_o   (txe_wrdata_o),
        .txe_wrusedw_i  (txe_wrusedw_i),
        .txe_wrfull_i   (txe_wrfull_i),
        .stream_data_i  (stream_data_i),
        .stream_valid_i (stream_valid_i),
        .stream_ready_o (stream_ready_o)
    );

endmodule

// File: tb/tb_usb_cmd_ctrl.sv
// Directed bench for usb_cmd_ctrl with small models of the rx FIFO, tx sink,
// register file and scan-data source.
module tb_usb_cmd_ctrl;

    logic        clk_i = 1'b0;
    logic        nrst  = 1'b0;
    logic        rxf_rdreq_o;
    logic [7:0]  rxf_rddata_i = 8'h00;
    logic [8:0]  rxf_rdusedw_i;
    logic        txe_wrreq_o;
    logic [7:0]  txe_wrdata_o;
    logic [8:0]  txe_wrusedw_i = 9'd0;
    logic        txe_wrfull_i = 1'b0;
    logic        reg_wr_o;
    logic        reg_rd_o;
    logic [7:0]  reg_addr_o;
    logic [15:0] reg_wdata_o;
    logic [15:0] reg_rdata_i = 16'h0000;
    logic [7:0]  stream_data_i;
    logic        stream_valid_i;
    logic        stream_ready_o;
    logic [7:0]  err_cnt_o;

    int n_cmp = 0;
    int n_bad = 0;

    usb_cmd_ctrl dut (
        .clk_i          (clk_i),
        .nrst           (nrst),
        .rxf_rdreq_o    (rxf_rdreq_o),
        .rxf_rddata_i   (rxf_rddata_i),
        .rxf_rdusedw_i  (rxf_rdusedw_i),
        .txe_wrreq_o    (txe_wrreq_o),
        .txe_wrdata_o   (txe_wrdata_o),
        .txe_wrusedw_i  (txe_wrusedw_i),
        .txe_wrfull_i   (txe_wrfull_i),
        .reg_wr_o       (reg_wr_o),
        .reg_rd_o       (reg_rd_o),
        .reg_addr_o     (reg_addr_o),
        .reg_wdata_o    (reg_wdata_o),
        .reg_rdata_i    (reg_rdata_i),
        .stream_data_i  (stream_data_i),
        .stream_valid_i (stream_valid_i),
        .stream_ready_o (stream_ready_o),
        .err_cnt_o      (err_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Receive FIFO model: non-showahead, data valid the cycle after rdreq.
    logic [7:0] rx_mem [0:255];
    int rx_wp = 0;
    int rx_rp = 0;
    assign rxf_rdusedw_i = 9'(rx_wp - rx_rp);
    always @(posedge clk_i) begin
        if (rxf_rdreq_o && rx_rp < rx_wp) begin
            rxf_rddata_i <= rx_mem[rx_rp];
            rx_rp        <= rx_rp + 1;
        end
    end

    // Transmit sink log.
    logic [7:0] tx_log [0:1023];
    int tx_n = 0;
    always @(posedge clk_i) begin
        if (txe_wrreq_o) begin
            tx_log[tx_n] <= txe_wrdata_o;
            tx_n         <= tx_n + 1;
        end
    end

    // Register file model: read data valid exactly one cycle after reg_rd_o.
    logic [15:0] rd_val = 16'hBEEF;
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    logic [7:0]  wr_addr = 8'h00;
    logic [15:0] wr_data = 16'h0000;
    logic [7:0]  rd_addr = 8'h00;
    always @(posedge clk_i) begin
        if (reg_wr_o) begin
            wr_cnt  <= wr_cnt + 1;
            wr_addr <= reg_addr_o;
            wr_data <= reg_wdata_o;
        end
        if (reg_rd_o) begin
            rd_cnt  <= rd_cnt + 1;
            rd_addr <= reg_addr_o;
        end
        reg_rdata_i <= reg_rd_o ? rd_val : 16'h0000;
    end

    // Scan-data source: byte k carries value k.
    int   s_idx   = 0;
    int   s_total = 0;
    logic s_en    = 1'b0;
    logic s_clr   = 1'b0;
    assign stream_valid_i = s_en && (s_idx < s_total);
    assign stream_data_i  = 8'(s_idx);
    always @(posedge clk_i) begin
        if (s_clr) s_idx <= 0;
        else if (stream_valid_i && stream_ready_o) s_idx <= s_idx + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3, input logic [7:0] b4);
        rx_mem[rx_wp]     = b0;
        rx_mem[rx_wp + 1] = b1;
        rx_mem[rx_wp + 2] = b2;
        rx_mem[rx_wp + 3] = b3;
        rx_mem[rx_wp + 4] = b4;
        rx_wp             = rx_wp + 5;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rdreq"}, 32'(rxf_rdreq_o), 0);
        check({tag, "_wrreq"}, 32'(txe_wrreq_o), 0);
        check({tag, "_wrdata"}, 32'(txe_wrdata_o), 0);
        check({tag, "_reg_wr"}, 32'(reg_wr_o), 0);
        check({tag, "_reg_rd"}, 32'(reg_rd_o), 0);
        check({tag, "_reg_addr"}, 32'(reg_addr_o), 0);
        check({tag, "_reg_wdata"}, 32'(reg_wdata_o), 0);
        check({tag, "_ready"}, 32'(stream_ready_o), 0);
        check({tag, "_err"}, 32'(err_cnt_o), 0);
    endtask

    initial begin
        int base;
        int bad;
        int k;
        logic [7:0] exp_b;

        // Reset state
        repeat (3) tick();
        check_outputs_zero("reset");
        nrst = 1'b1;
        repeat (2) tick();

        // Register write
        push_pkt(8'hA5, 8'h01, 8'h10, 8'h12, 8'h34);
        repeat (30) tick();
        check("wr_count", wr_cnt, 1);
        check("wr_addr", 32'(wr_addr), 32'h10);
        check("wr_data", 32'(wr_data), 32'h1234);
        check("wr_hold_addr", 32'(reg_addr_o), 32'h10);
        check("wr_hold_data", 32'(reg_wdata_o), 32'h1234);
        check("wr_no_tx", tx_n, 0);
        check("wr_no_rd", rd_cnt, 0);
        check("wr_err", 32'(err_cnt_o), 0);

        // Register read
        push_pkt(8'hA5, 8'h02, 8'h22, 8'h00, 8'h00);
        repeat (40) tick();
        check("rd_count", rd_cnt, 1);
        check("rd_addr", 32'(rd_addr), 32'h22);
        check("rd_tx_count", tx_n, 4);
        check("rd_b0", 32'(tx_log[0]), 32'h5A);
        check("rd_b1", 32'(tx_log[1]), 32'h22);
        check("rd_b2", 32'(tx_log[2]), 32'hBE);
        check("rd_b3", 32'(tx_log[3]), 32'hEF);
        check("rd_wr_count", wr_cnt, 1);

        // Framing and opcode errors, then a good write
        rx_mem[rx_wp] = 8'h00; rx_mem[rx_wp + 1] = 8'hFF;
        rx_mem[rx_wp + 2] = 8'hA5; rx_mem[rx_wp + 3] = 8'h07;
        rx_wp = rx_wp + 4;
        push_pkt(8'hA5, 8'h01, 8'h44, 8'h56, 8'h78);
        repeat (40) tick();
        check("err_count3", 32'(err_cnt_o), 3);
        check("err_wr_count", wr_cnt, 2);
        check("err_wr_addr", 32'(wr_addr), 32'h44);
        check("err_wr_data", 32'(wr_data), 32'h5678);

        // Arbitration: read issued during the first stream burst
        base = tx_n;
        s_total = 200;
        s_clr = 1'b1;
        tick();
        s_clr = 1'b0;
        s_en = 1'b1;
        repeat (5) tick();
        push_pkt(8'hA5, 8'h02, 8'h66, 8'h00, 8'h00);
        k = 0;
        while (tx_n < base + 204 && k < 1000) begin
            tick();
            k++;
        end
        repeat (5) tick();
        s_en = 1'b0;
        check("arb_tx_count", tx_n - base, 204);
        bad = 0;
        for (int i = 0; i < 204; i++) begin
            if (i < 64) exp_b = 8'(i);
            else if (i == 64) exp_b = 8'h5A;
            else if (i == 65) exp_b = 8'h66;
            else if (i == 66) exp_b = 8'hBE;
            else if (i == 67) exp_b = 8'hEF;
            else exp_b = 8'(i - 4);
            if (tx_log[base + i] !== exp_b) bad++;
        end
        check("arb_order_errors", bad, 0);
        check("arb_byte63", 32'(tx_log[base + 63]), 32'h3F);
        check("arb_rsp_hdr", 32'(tx_log[base + 64]), 32'h5A);
        check("arb_resume", 32'(tx_log[base + 68]), 32'h40);
        check("arb_rd_count", rd_cnt, 2);

        // Backpressure: full flag, then the high watermark boundary
        base = tx_n;
        txe_wrfull_i = 1'b1;
        txe_wrusedw_i = 9'd0;
        s_total = 20;
        s_clr = 1'b1;
        tick();
        s_clr = 1'b0;
        s_en = 1'b1;
        repeat (3) tick();
        check("bp_full_ready", 32'(stream_ready_o), 0);
        check("bp_full_tx", tx_n - base, 0);
        txe_wrfull_i = 1'b0;
        txe_wrusedw_i = 9'd496;
        repeat (4) tick();
        check("bp_wm_ready", 32'(stream_ready_o), 0);
        check("bp_wm_wrreq", 32'(txe_wrreq_o), 0);
        check("bp_wm_tx", tx_n - base, 0);
        txe_wrusedw_i = 9'd495;
        tick();
        check("bp_resume_wrreq", 32'(txe_wrreq_o), 1);
        check("bp_resume_ready", 32'(stream_ready_o), 1);
        tick();
        check("bp_first_byte", 32'(tx_log[base]), 0);
        txe_wrusedw_i = 9'd0;
        k = 0;
        while (s_idx < 20 && k < 200) begin
            tick();
            k++;
        end
        s_en = 1'b0;
        repeat (3) tick();
        check("bp_all_bytes", tx_n - base, 20);

        // Timeout mid-packet
        rx_mem[rx_wp] = 8'hA5; rx_mem[rx_wp + 1] = 8'h01;
        rx_wp = rx_wp + 2;
        k = 0;
        while (rx_rp < rx_wp && k < 50) begin
            tick();
            k++;
        end
        repeat (2) tick();
        repeat (65400) tick();
        check("to_not_yet", 32'(err_cnt_o), 3);
        k = 0;
        while (err_cnt_o == 8'd3 && k < 300) begin
            tick();
            k++;
        end
        check("to_fired", 32'(err_cnt_o), 4);
        push_pkt(8'hA5, 8'h01, 8'h5A, 8'h11, 8'h22);
        repeat (30) tick();
        check("to_hunt_wr_count", wr_cnt, 3);
        check("to_hunt_wr_addr", 32'(wr_addr), 32'h5A);
        check("to_hunt_wr_data", 32'(wr_data), 32'h1122);
        check("to_err_stable", 32'(err_cnt_o), 4);

        // Reset in the middle of a response
        base = tx_n;
        txe_wrusedw_i = 9'd496;
        push_pkt(8'hA5, 8'h02, 8'h77, 8'h00, 8'h00);
        repeat (30) tick();
        check("rst_stalled", tx_n - base, 0);
        txe_wrusedw_i = 9'd0;
        tick();
        tick();
        txe_wrusedw_i = 9'd496;
        repeat (3) tick();
        check("rst_partial_count", tx_n - base, 2);
        check("rst_partial_b0", 32'(tx_log[base]), 32'h5A);
        check("rst_partial_b1", 32'(tx_log[base + 1]), 32'h77);
        nrst = 1'b0;
        #1;
        check_outputs_zero("rst_mid");
        tick();
        nrst = 1'b1;
        txe_wrusedw_i = 9'd0;
        repeat (30) tick();
        check("rst_no_more_tx", tx_n - base, 2);
        check("rst_err_clear", 32'(err_cnt_o), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/usb_cmd_ctrl.md
Name: usb_cmd_ctrl

Overview:
Single-clock command controller on the user side of usb_ft232h. Pops host bytes from the receive FIFO, frames and decodes fixed 5-byte command packets, and executes register writes and reads. It also arbitrates the transmit FIFO between 4-byte read responses and the bulk scan-data stream. All FIFO user ports of usb_ft232h (rxf_rdclk_i, txe_wrclk_i) are driven from clk_i.

Parameters:
BURST_LEN, 64, maximum stream bytes written per grant before the arbiter re-evaluates.
TX_HIGH_WM, 496, no transmit write is issued while txe_wrusedw_i >= this value (FIFO depth 512).
TIMEOUT, 65535, idle cycles allowed mid-packet before the parser aborts to HUNT.

Ports:
clk_i  in  1  system clock; also drives the usb_ft232h FIFO read and write clocks.
nrst  in  1  asynchronous active-low reset.
rxf_rdreq_o  out  1  receive FIFO read request.
rxf_rddata_i  in  8  receive FIFO data; valid in the cycle after rdreq (non-showahead).
rxf_rdusedw_i  in  9  receive FIFO fill level.
txe_wrreq_o  out  1  transmit FIFO write request.
txe_wrdata_o  out  8  transmit FIFO write data.
txe_wrusedw_i  in  9  transmit FIFO fill level.
txe_wrfull_i  in  1  transmit FIFO full flag.
reg_wr_o  out  1  one-cycle register write strobe.
reg_rd_o  out  1  one-cycle register read strobe.
reg_addr_o  out  8  register address.
reg_wdata_o  out  16  register write data.
reg_rdata_i  in  16  register read data; valid exactly 1 cycle after reg_rd_o.
stream_data_i  in  8  scan-data byte.
stream_valid_i  in  1  scan-data byte available.
stream_ready_o  out  1  scan-data byte accepted when valid && ready.
err_cnt_o  out  8  saturating count of framing errors, bad-opcode errors and timeouts.

Behaviour:
- Reset: every output is 0; parser is in HUNT; arbiter is IDLE; timeout counter is 0; err_cnt_o is 0. Reset may be asserted at any time, including mid-packet or mid-burst: all state is abandoned, and no partial response is written after reset deasserts.
- Packet format, in arrival order: 0xA5, opcode, addr, dhi, dlo.
  - Opcode 0x01: register write of {dhi,dlo}.
  - Opcode 0x02: register read; dhi and dlo are ignored but must still be sent.
- Byte fetch:
  - Assert rxf_rdreq_o for one cycle only when rxf_rdusedw_i != 0 and no fetch is outstanding.
  - The byte is consumed on the following cycle.
  - Maximum throughput is one byte every 2 cycles.
- Parser states:
  - HUNT: a byte other than 0xA5 is discarded and increments err_cnt_o.
  - OPC: 0x01 or 0x02 goes to ADDR; any other value increments err_cnt_o and returns to HUNT.
  - ADDR, DHI, DLO: capture the byte and advance; DLO goes to EXEC.
  - EXEC, opcode 0x01: pulse reg_wr_o for 1 cycle with reg_addr_o and reg_wdata_o, then go to HUNT.
  - EXEC, opcode 0x02: if the response buffer is busy, wait in EXEC. Otherwise pulse reg_rd_o, then go to RD_CAP.
  - RD_CAP: latch reg_rdata_i into the response buffer {0x5A, addr, rdata[15:8], rdata[7:0]}, mark it full, go to HUNT.
- Timeout:
  - In OPC, ADDR, DHI and DLO, the counter increments each cycle with no byte received and clears on each byte.
  - At count == TIMEOUT: increment err_cnt_o and go to HUNT.
  - The counter is held at 0 in HUNT and EXEC.
- Register outputs: reg_addr_o and reg_wdata_o hold their last values between strobes.
- Transmit write gate: tx_ok = !txe_wrfull_i && txe_wrusedw_i < TX_HIGH_WM. A byte is written (txe_wrreq_o = 1, data registered alongside it) only in a cycle where tx_ok is true.
- Arbiter states:
  - IDLE: if the response buffer is full, go to RESP. Otherwise, if stream_valid_i, go to STREAM. Response always wins a simultaneous request.
  - RESP: write the 4 response bytes in order, stalling while !tx_ok. After the 4th byte, clear the buffer and go to IDLE. A response is never interleaved with stream bytes.
  - STREAM: stream_ready_o = tx_ok. Each accepted byte is written in the same cycle and increments the burst count.
  - Leave STREAM for IDLE when the burst count reaches BURST_LEN, or when stream_valid_i is low while the response buffer is full.
  - The burst count clears on entry to STREAM.
- err_cnt_o saturates at 255.

Decomposition:
- Package usb_cmd_pkg holds:
  - constants CMD_HDR = 8'hA5, RSP_HDR = 8'h5A, OP_WR = 8'h01, OP_RD = 8'h02;
  - the parser state enum (HUNT, OPC, ADDR, DHI, DLO, EXEC, RD_CAP);
  - the arbiter state enum (IDLE, RESP, STREAM).
- One sub-module, usb_tx_arb: the transmit arbiter plus the 4-byte response buffer, driving txe_wr* and stream_ready_o. The parser lives in the top level.

Test Plan:
- Register write: push A5 01 10 12 34 -> exactly one reg_wr_o pulse with addr 0x10 and wdata 0x1234; no transmit writes; err_cnt_o stays 0.
- Register read: push A5 02 22 00 00 with reg_rdata_i = 0xBEEF -> one reg_rd_o pulse, then transmit bytes 5A 22 BE EF in order.
- Framing and opcode errors: push 00 FF A5 07 then a valid write packet -> err_cnt_o = 3 and the valid write still executes correctly.
- Arbitration: stream_valid_i held high with 200 bytes, read command issued mid-burst -> the first 64 stream bytes complete uninterrupted, then the 4 response bytes, then the stream resumes; no bytes are lost or duplicated.
- Backpressure: txe_wrusedw_i = 496 -> txe_wrreq_o and stream_ready_o stay 0; dropping it to 495 resumes writes on the next cycle.
- Timeout and reset: push A5 01 then stall for 65535 cycles -> err_cnt_o increments and the parser is back in HUNT. Separately, assert nrst mid-response -> all outputs 0 and no remaining response bytes are written.
